// File: rtl/seg_pkg.sv
// Shared constants for 7-segment capture/decode blocks: segment codes,
// digit-select encodings and the capture FSM state type.
package seg_pkg;

  localparam logic [6:0] SEG_CODE_0 = 7'h3f;
  localparam logic [6:0] SEG_CODE_1 = 7'h06;
  localparam logic [6:0] SEG_CODE_2 = 7'h5b;
  localparam logic [6:0] SEG_CODE_3 = 7'h4f;
  localparam logic [6:0] SEG_CODE_4 = 7'h66;
  localparam logic [6:0] SEG_CODE_5 = 7'h6d;
  localparam logic [6:0] SEG_CODE_6 = 7'h7d;
  localparam logic [6:0] SEG_CODE_7 = 7'h07;
  localparam logic [6:0] SEG_CODE_8 = 7'h7f;
  localparam logic [6:0] SEG_CODE_9 = 7'h6f;
  localparam logic [6:0] SEG_BLANK  = 7'h00;

  localparam logic [1:0] DIG_SEL_H = 2'b01;
  localparam logic [1:0] DIG_SEL_L = 2'b10;

  typedef enum logic [1:0] {
    WAIT  = 2'd0,
    COUNT = 2'd1,
    HELD  = 2'd2
  } state_e;

  function automatic logic is_digit_sel(input logic [1:0] sel);
    return (sel == DIG_SEL_H) || (sel == DIG_SEL_L);
  endfunction

endpackage

// File: rtl/seg_pattern_decode.sv
// Combinational 7-segment pattern to BCD decoder; blank and any
// non-digit pattern report legal_o = 0 with digit_o = 0.
module seg_pattern_decode
  import seg_pkg::*;
(
  input  logic [6:0] pattern_i,
  output logic       legal_o,
  output logic [3:0] digit_o
);

  always_comb begin
    legal_o = 1'b1;
    digit_o = 4'd0;
    case (pattern_i)
      SEG_CODE_0: digit_o = 4'd0;
      SEG_CODE_1: digit_o = 4'd1;
      SEG_CODE_2: digit_o = 4'd2;
      SEG_CODE_3: digit_o = 4'd3;
      SEG_CODE_4: digit_o = 4'd4;
      SEG_CODE_5: digit_o = 4'd5;
      SEG_CODE_6: digit_o = 4'd6;
      SEG_CODE_7: digit_o = 4'd7;
      SEG_CODE_8: digit_o = 4'd8;
      SEG_CODE_9: digit_o = 4'd9;
      default:    legal_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg_scan_capture.sv
// Captures the tens/units digits of a multiplexed 7-segment scan once each
// digit has held steady. SEG_DP_IGNORE_EN masks the decimal point (bs[7]).
module seg_scan_capture
  import seg_pkg::*;
#(
  parameter int STABLE_CYCLES = 16,
  parameter int RUN_W         = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] seg,
  input  logic [7:0] bs,
  output logic [3:0] time_h,
  output logic [3:0] time_l,
  output logic       valid,
  output logic       update,
  output logic       pattern_err
);

  localparam logic [RUN_W-1:0] RUN_TARGET = RUN_W'(STABLE_CYCLES);
  localparam logic [RUN_W-1:0] RUN_ONE    = RUN_W'(1);

  logic [9:0]       sample_in, sample_q;
  logic [RUN_W-1:0] run_q, run_d;
  state_e           state_q, state_d;
  logic             commit;

  logic [3:0] time_h_q, time_h_d, time_l_q, time_l_d;
  logic       cap_h_q, cap_h_d, cap_l_q, cap_l_d;
  logic       valid_q, valid_d, update_q, update_d, perr_q, perr_d;

  logic       dec_legal, legal;
  logic [3:0] dec_digit;
  logic       sel_ok;

`ifdef SEG_DP_IGNORE_EN
  assign sample_in = {seg, 1'b0, bs[6:0]};
`else
  assign sample_in = {seg, bs};
`endif

  seg_pattern_decode u_decode (
    .pattern_i (sample_q[6:0]),
    .legal_o   (dec_legal),
    .digit_o   (dec_digit)
  );

  // A set dp bit can only reach here when it is not masked at the input.
  assign legal  = dec_legal & ~sample_q[7];
  assign sel_ok = is_digit_sel(sample_q[9:8]);

  always_comb begin
    if (sample_in != sample_q) begin
      run_d = RUN_ONE;
    end else if (run_q >= RUN_TARGET) begin
      run_d = run_q;
    end else begin
      run_d = run_q + RUN_ONE;
    end
  end

  // run_q == 1 marks the first cycle of a new sample value.
  always_comb begin
    state_d = state_q;
    commit  = 1'b0;
    case (state_q)
      WAIT: begin
        if (sel_ok) state_d = COUNT;
      end
      COUNT: begin
        if (!sel_ok) begin
          state_d = WAIT;
        end else if (run_q == RUN_TARGET) begin
          commit  = 1'b1;
          state_d = HELD;
        end
      end
      HELD: begin
        if (!sel_ok) begin
          state_d = WAIT;
        end else if (run_q == RUN_ONE) begin
          state_d = COUNT;
        end
      end
      default: state_d = WAIT;
    endcase
  end

  always_comb begin
    time_h_d = time_h_q;
    time_l_d = time_l_q;
    cap_h_d  = cap_h_q;
    cap_l_d  = cap_l_q;
    update_d = 1'b0;
    perr_d   = 1'b0;
    if (commit) begin
      if (!legal) begin
        perr_d = 1'b1;
      end else if (sample_q[9:8] == DIG_SEL_H) begin
        time_h_d = dec_digit;
        cap_h_d  = 1'b1;
        update_d = (dec_digit != time_h_q);
      end else begin
        time_l_d = dec_digit;
        cap_l_d  = 1'b1;
        update_d = (dec_digit != time_l_q);
      end
    end
    valid_d = cap_h_d & cap_l_d;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sample_q <= {2'b11, 8'h00};
      run_q    <= '0;
      state_q  <= WAIT;
      time_h_q <= 4'd0;
      time_l_q <= 4'd0;
      cap_h_q  <= 1'b0;
      cap_l_q  <= 1'b0;
      valid_q  <= 1'b0;
      update_q <= 1'b0;
      perr_q   <= 1'b0;
    end else begin
      sample_q <= sample_in;
      run_q    <= run_d;
      state_q  <= state_d;
      time_h_q <= time_h_d;
      time_l_q <= time_l_d;
      cap_h_q  <= cap_h_d;
      cap_l_q  <= cap_l_d;
      valid_q  <= valid_d;
      update_q <= update_d;
      perr_q   <= perr_d;
    end
  end

  assign time_h      = time_h_q;
  assign time_l      = time_l_q;
  assign valid       = valid_q;
  assign update      = update_q;
  assign pattern_err = perr_q;

endmodule

// File: tb/tb_seg_scan_capture.sv
// Directed bench for seg_scan_capture (STABLE_CYCLES = 16), checking
// capture latency, glitch rejection, illegal patterns and reset.
module tb_seg_scan_capture;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] seg   = 2'b11;
  logic [7:0] bs    = 8'h00;
  logic [3:0] time_h, time_l;
  logic       valid, update, pattern_err;

  int compared   = 0;
  int mismatched = 0;
  int upd_cnt    = 0;
  int perr_cnt   = 0;
  bit both_seen  = 1'b0;
  bit seen3      = 1'b0;
  int upd_base, perr_base;
  logic [3:0] exp_h;

  seg_scan_capture #(.STABLE_CYCLES(16), .RUN_W(16)) dut (
    .clock       (clock),
    .reset       (reset),
    .seg         (seg),
    .bs          (bs),
    .time_h      (time_h),
    .time_l      (time_l),
    .valid       (valid),
    .update      (update),
    .pattern_err (pattern_err)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (update) upd_cnt++;
    if (pattern_err) perr_cnt++;
    if (update && pattern_err) both_seen = 1'b1;
    if (time_h == 4'd3) seen3 = 1'b1;
  end

  task automatic step(input int n);
    repeat (n) @(negedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic mark();
    upd_base  = upd_cnt;
    perr_base = perr_cnt;
  endtask

  initial begin
    // reset with random inputs
    seg = 2'($urandom);
    bs  = 8'($urandom);
    step(2);
    check("rst_time_h", 32'(time_h), 32'd0);
    check("rst_time_l", 32'(time_l), 32'd0);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_update", 32'(update), 32'd0);
    check("rst_perr", 32'(pattern_err), 32'd0);

    seg = 2'b11; bs = 8'h00;
    reset = 1'b0;
    mark();
    step(50);
    check("idle_time_h", 32'(time_h), 32'd0);
    check("idle_time_l", 32'(time_l), 32'd0);
    check("idle_valid", 32'(valid), 32'd0);
    check("idle_pulses", 32'(upd_cnt - upd_base + perr_cnt - perr_base), 32'd0);

    // tens digit 2
    mark();
    seg = 2'b01; bs = 8'h5b;
    step(16);
    check("h_before_latency", 32'(time_h), 32'd0);
    step(1);
    check("h_commit", 32'(time_h), 32'd2);
    check("h_update_pulse", 32'(update), 32'd1);
    step(3);
    check("h_update_count", 32'(upd_cnt - upd_base), 32'd1);
    check("h_valid_low", 32'(valid), 32'd0);

    // units digit 5
    mark();
    seg = 2'b10; bs = 8'h6d;
    step(16);
    check("l_before_latency", 32'(time_l), 32'd0);
    check("l_valid_before", 32'(valid), 32'd0);
    step(1);
    check("l_commit", 32'(time_l), 32'd5);
    check("l_valid_rise", 32'(valid), 32'd1);
    check("l_update_pulse", 32'(update), 32'd1);
    step(3);
    check("l_update_count", 32'(upd_cnt - upd_base), 32'd1);

    // re-scan same digits: commits without updates
    mark();
    seg = 2'b00; bs = 8'h00;
    step(3);
    seg = 2'b01; bs = 8'h5b;
    step(20);
    seg = 2'b10; bs = 8'h6d;
    step(20);
    check("rescan_update", 32'(upd_cnt - upd_base), 32'd0);
    check("rescan_perr", 32'(perr_cnt - perr_base), 32'd0);
    check("rescan_h", 32'(time_h), 32'd2);
    check("rescan_l", 32'(time_l), 32'd5);
    check("rescan_valid", 32'(valid), 32'd1);

    // glitch: 3 for 10 cycles then 4
    mark();
    seg = 2'b01; bs = 8'h4f;
    step(10);
    check("glitch_hold_old", 32'(time_h), 32'd2);
    bs = 8'h66;
    step(16);
    check("glitch_not_yet", 32'(time_h), 32'd2);
    step(1);
    check("glitch_commit4", 32'(time_h), 32'd4);
    step(3);
    check("glitch_update_count", 32'(upd_cnt - upd_base), 32'd1);
    check("glitch_never3", 32'(seen3), 32'd0);

    // illegal pattern 0x49
    mark();
    seg = 2'b10; bs = 8'h49;
    step(20);
    check("illegal_perr_count", 32'(perr_cnt - perr_base), 32'd1);
    check("illegal_no_update", 32'(upd_cnt - upd_base), 32'd0);
    check("illegal_l_kept", 32'(time_l), 32'd5);

    // decimal point set on digit 0
    mark();
    seg = 2'b01; bs = 8'hbf;
    step(20);
`ifdef SEG_DP_IGNORE_EN
    exp_h = 4'd0;
    check("dp_h", 32'(time_h), 32'd0);
    check("dp_update", 32'(upd_cnt - upd_base), 32'd1);
    check("dp_perr", 32'(perr_cnt - perr_base), 32'd0);
`else
    exp_h = 4'd4;
    check("dp_h", 32'(time_h), 32'd4);
    check("dp_update", 32'(upd_cnt - upd_base), 32'd0);
    check("dp_perr", 32'(perr_cnt - perr_base), 32'd1);
`endif

    // blank pattern is illegal
    mark();
    seg = 2'b01; bs = 8'h00;
    step(20);
    check("blank_perr", 32'(perr_cnt - perr_base), 32'd1);
    check("blank_h_kept", 32'(time_h), 32'(exp_h));

    // reset in the middle of a count
    mark();
    seg = 2'b10; bs = 8'h07;
    step(8);
    reset = 1'b1;
    #1;
    check("midrst_time_h", 32'(time_h), 32'd0);
    check("midrst_time_l", 32'(time_l), 32'd0);
    check("midrst_valid", 32'(valid), 32'd0);
    seg = 2'b11; bs = 8'h00;
    step(2);
    reset = 1'b0;
    step(20);
    check("midrst_no_commit_l", 32'(time_l), 32'd0);
    check("midrst_valid_after", 32'(valid), 32'd0);
    check("midrst_no_update", 32'(upd_cnt - upd_base), 32'd0);

    check("never_both_pulses", 32'(both_seen), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
